dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the datapath's data port: answers the pipeline's dmemREN/dmemWEN/datomic requests with dhit/dmemload and forwards each access to a single-word RAM port. It sits between the EX/MEM-driven data request lines and the memory/bus side of one core. It implements LR/SC reservation tracking, and the reservation is invalidated by the other core's snooped writes.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- dmemREN  in  1  data read request; held by the requester until dhit.
- dmemWEN  in  1  data write request; held until dhit.
- datomic  in  1  qualifies the request: LR with REN, SC with WEN.
- dmemaddr  in  ADDR_W  request byte address.
- dmemstore  in  DATA_W  write data.
- dhit  out  1  one-cycle completion pulse.
- dmemload  out  DATA_W  read data; SC status for SC requests (0 = success, 1 = fail).
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data; valid when ram_ready is high.
- ram_ready  in  1  RAM completes the current strobe this cycle.
- snoop_valid  in  1  the other core commits a write this cycle.
- snoop_addr  in  ADDR_W  address of that write.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On dmemREN or dmemWEN, latch addr, store data and kind, then go to ACCESS.
  - If both REN and WEN are high, the request is treated as a write.
  - A failed SC skips ACCESS and goes to RESP with the load register set to 1.
- ACCESS:
  - Drive ramREN or ramWEN, ramaddr and ramstore from the latched values. Hold them stable until ram_ready.
  - On ram_ready, capture ramload for reads (0 for a successful SC, 0 for a plain write) and go to RESP.
- RESP:
  - dhit = 1 and dmemload = the captured value. Return to IDLE.
  - Requests present in RESP are ignored, because the requester drops its request on the edge after dhit.
- dmemload holds its last value outside RESP. Only the RESP cycle is meaningful.
- Reservation (valid bit plus word address, compared on [ADDR_W-1:2]):
  - LR sets the reservation at its ACCESS completion.
  - An SC is evaluated in the IDLE acceptance cycle and clears the reservation whether it passes or fails.
  - A plain write by this core to the reserved word clears it at acceptance.
  - snoop_valid with a matching word clears it.
- Simultaneous events:
  - A snoop in the same cycle as an LR completion: the reservation ends invalid.
  - A snoop in the same cycle as SC acceptance: the SC fails.
  - A snoop arriving while an accepted SC is already in ACCESS does not abort the write.
- Reset (including mid-ACCESS):
  - Next state is IDLE and the reservation is cleared.
  - RAM strobes are low from the cycle after RST is sampled.
  - No dhit is issued for the aborted request.

## Timing
- Reset values: dhit 0, dmemload 0, ramREN 0, ramWEN 0, ramaddr 0, ramstore 0; FSM in IDLE; reservation invalid.
- The request is sampled in cycle t (IDLE). Strobes are active from t+1.
- If ram_ready arrives in cycle t+k (k ≥ 1), dhit is asserted in cycle t+k+1. Minimum request-to-dhit latency is 2 cycles.
- A failed SC asserts dhit at t+1 with no RAM strobe.
- Back-to-back throughput: the earliest next acceptance is the cycle after RESP.
- All outputs are registered or decoded from registered state only. There is no combinational path from request inputs to the RAM outputs.

## Configuration
- DMEM_RESPONDER_ATOMIC_EN defined: LR/SC reservation logic and the SC fast-fail path are present, as described above.
- DMEM_RESPONDER_ATOMIC_EN undefined:
  - datomic is ignored. LR behaves as a plain read and SC as a plain write that always performs the RAM access and returns dmemload = 0.
  - snoop inputs are unused.
  - No reservation registers are instantiated.

## Structure
- Shared package (alongside cpu_types_pkg): dresp_state_t enum (IDLE, ACCESS, RESP), SC_SUCCESS = 0 and SC_FAIL = 1 constants. word_t is reused from cpu_types_pkg.
- One sub-module: lr_sc_reservation.
  - Inputs: set, set_addr, clear, check_addr, snoop_valid, snoop_addr.
  - Output: match.
  - Instantiated only under DMEM_RESPONDER_ATOMIC_EN.

## Test plan
- Read at 0x100, ram_ready after 3 ACCESS cycles, ramload = 0xDEADBEEF -> ramREN high for exactly 3 cycles, dhit 1 cycle later with dmemload = 0xDEADBEEF.
- Write 0x12345678 to 0x200 with ram_ready immediate -> one ramWEN cycle at 0x200 with ramstore = 0x12345678, dhit 2 cycles after request.
- LR at 0x300 then SC at 0x300 with no snoop -> SC performs ramWEN, dmemload = 0; a second SC at 0x300 fails (dmemload = 1, dhit at t+1, no strobe).
- LR at 0x300, then snoop_valid with snoop_addr = 0x302, then SC at 0x300 -> SC fails with dmemload = 1 and no ramWEN.
- RST pulsed in the second ACCESS cycle of a read -> strobes drop next cycle, no dhit, reservation invalid, and a new read is accepted normally.
- REN held through RESP -> exactly one RAM access and one dhit per request.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Core-wide shared types used by the datapath and its memory-side helpers.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/dmem_responder_pkg.sv
// Types and constants for the data-memory responder.
// This package holds the FSM state encoding and the SC status codes.
package dmem_responder_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } dresp_state_t;

    localparam word_t SC_SUCCESS = 32'd0;
    localparam word_t SC_FAIL    = 32'd1;

endpackage

// File: rtl/dmem_responder_if.sv
// Bundles the data-port request lines, the RAM port and the snoop bus of one core.
// The slave modport is the responder's view. The master modport is the view of the pipeline, RAM and snoop side.
interface dmem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              dmemREN;
    logic              dmemWEN;
    logic              datomic;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;

    logic              snoop_valid;
    logic [ADDR_W-1:0] snoop_addr;

    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dhit, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ram_ready,
        output snoop_valid, snoop_addr
    );

    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dhit, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ram_ready,
        input  snoop_valid, snoop_addr
    );

endinterface

// File: rtl/dmem_responder_lr_sc_reservation.sv
// LR/SC reservation: a valid bit and a word address. Other-core writes to the reserved word invalidate it.
// Only instantiated when DMEM_RESPONDER_ATOMIC_EN is defined.
module lr_sc_reservation #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clear,
    input  logic [ADDR_W-1:0] check_addr,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              match
);

    logic              valid_q;
    logic [ADDR_W-3:0] word_q;
    logic              snoop_hit;
    logic              snoop_on_set;
    logic              unused_offsets;

    assign snoop_hit      = snoop_valid && (snoop_addr[ADDR_W-1:2] == word_q);
    assign snoop_on_set   = snoop_valid && (snoop_addr[ADDR_W-1:2] == set_addr[ADDR_W-1:2]);
    assign unused_offsets = ^{set_addr[1:0], check_addr[1:0], snoop_addr[1:0]};

    // A snoop landing in the same cycle as the check must already make an SC fail.
    assign match = valid_q && !snoop_hit && (check_addr[ADDR_W-1:2] == word_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (set) begin
            valid_q <= !snoop_on_set;
            word_q  <= set_addr[ADDR_W-1:2];
        end else if (snoop_hit) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: answers the pipeline's data requests with dhit/dmemload and runs each access on a single-word RAM port.
// Define DMEM_RESPONDER_ATOMIC_EN to build the LR/SC reservation and the SC fast-fail path.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           CLK,
    input  logic           RST,
    dmem_responder_if.slave bus
);

    dresp_state_t      state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic [DATA_W-1:0] load_q;
    logic              is_write_q;
    logic              dhit_q;
    logic              ram_ren_q;
    logic              ram_wen_q;
    logic              req_valid;
    logic              req_write;
    logic              sc_fail;

    assign req_valid = bus.dmemREN | bus.dmemWEN;
    assign req_write = bus.dmemWEN;

`ifdef DMEM_RESPONDER_ATOMIC_EN
    logic is_lr_q;
    logic resv_match;
    logic resv_set;
    logic resv_clear;

    // Any SC at acceptance, and a plain write to the reserved word, both consume the reservation.
    assign resv_set   = (state == ACCESS) && bus.ram_ready && is_lr_q;
    assign resv_clear = (state == IDLE) && req_write && (bus.datomic || resv_match);
    assign sc_fail    = req_write && bus.datomic && !resv_match;

    lr_sc_reservation #(
        .ADDR_W(ADDR_W)
    ) u_reservation (
        .CLK        (CLK),
        .RST        (RST),
        .set        (resv_set),
        .set_addr   (addr_q),
        .clear      (resv_clear),
        .check_addr (bus.dmemaddr),
        .snoop_valid(bus.snoop_valid),
        .snoop_addr (bus.snoop_addr),
        .match      (resv_match)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            is_lr_q <= 1'b0;
        end else if ((state == IDLE) && req_valid) begin
            is_lr_q <= !req_write && bus.datomic;
        end
    end
`else
    logic unused_atomic;

    assign unused_atomic = ^{bus.datomic, bus.snoop_valid, bus.snoop_addr};
    assign sc_fail       = 1'b0;
`endif

    // Request lines are only sampled in IDLE, so a request still held during RESP is ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            load_q     <= '0;
            is_write_q <= 1'b0;
            dhit_q     <= 1'b0;
            ram_ren_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
        end else begin
            dhit_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= bus.dmemaddr;
                        store_q    <= bus.dmemstore;
                        is_write_q <= req_write;
                        if (sc_fail) begin
                            load_q <= DATA_W'(SC_FAIL);
                            dhit_q <= 1'b1;
                            state  <= RESP;
                        end else begin
                            ram_ren_q <= !req_write;
                            ram_wen_q <= req_write;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.ram_ready) begin
                        ram_ren_q <= 1'b0;
                        ram_wen_q <= 1'b0;
                        load_q    <= is_write_q ? DATA_W'(SC_SUCCESS) : bus.ramload;
                        dhit_q    <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dhit     = dhit_q;
    assign bus.dmemload = load_q;
    assign bus.ramREN   = ram_ren_q;
    assign bus.ramWEN   = ram_wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;

endmodule
